// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/REQ/WAIT/HOLD) with one outstanding request, decoder stall and branch redirect.
// Optional macro FETCH_ALIGN_CHK_EN: misaligned redirect raises sticky fetch_fault and halts fetch until rst.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
`ifdef FETCH_ALIGN_CHK_EN
  output logic        fetch_fault,
`endif
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        inst_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic        req_q;
  logic        drop_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;

  logic redir_act;
  logic redir_bad;
  logic rsp_hit;
  logic drop_d;
  logic drop_redir_d;

  always_comb begin
    redir_act = redirect_en && (state_q != IDLE);
`ifdef FETCH_ALIGN_CHK_EN
    redir_bad = (redirect_pc[1:0] != 2'b00);
`else
    redir_bad = 1'b0;
`endif
    rsp_hit = imem_rvalid && !drop_q;
    drop_d  = drop_q && !imem_rvalid;
    // A response is still owed to us after a redirect if a request was issued
    // this cycle or is in flight and did not just land.
    drop_redir_d = (state_q == REQ) || ((state_q == WAIT) && !rsp_hit) || drop_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      inst_q    <= NOP;
      inst_pc_q <= 64'h0;
    end else if (redir_act && redir_bad) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      fault_q <= 1'b1;
    end else if (redir_act) begin
      state_q <= REQ;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      drop_q  <= drop_redir_d;
      pc_q    <= redirect_pc & ~64'd3;
    end else begin
      req_q  <= 1'b0;
      drop_q <= drop_d;
      case (state_q)
        IDLE: begin
          if (!fault_q) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (rsp_hit) begin
            inst_q    <= imem_rdata;
            inst_pc_q <= pc_q;
            valid_q   <= 1'b1;
            pc_q      <= pc_q + 64'd4;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level memory and output model plus literal scenario checks.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req, imem_rvalid = 1'b0, stall = 1'b0, redirect_en = 1'b0, inst_valid;
  logic [63:0] imem_addr, redirect_pc = 64'h0, inst_pc;
  logic [31:0] imem_rdata = 32'h0, inst_out;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_fault, h_fault;
`endif

  logic        h_req, h_rvalid = 1'b0, h_valid, h_req_prev = 1'b0;
  logic [63:0] h_addr, h_pc;
  logic [31:0] h_inst, h_rdata = 32'h1234_5678;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
`ifdef FETCH_ALIGN_CHK_EN
    .fetch_fault(fetch_fault),
`endif
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst), .imem_req(h_req), .imem_addr(h_addr),
    .imem_rvalid(h_rvalid), .imem_rdata(h_rdata), .stall(1'b0),
    .redirect_en(1'b0), .redirect_pc(64'h0),
`ifdef FETCH_ALIGN_CHK_EN
    .fetch_fault(h_fault),
`endif
    .inst_out(h_inst), .inst_pc(h_pc), .inst_valid(h_valid)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h00A0_0093 ^ {a[27:0], 4'h0} ^ a[63:32];
  endfunction

  // Memory: in-order responses, fixed latency, each tagged with its request.
  typedef struct {
    int          due;
    logic [63:0] addr;
    int          tag;
  } resp_t;
  resp_t       memq[$];
  int          cyc = 0;
  int          lat = 1;
  bit          inj = 1'b0;
  int          cur_tag = -2;
  logic [63:0] cur_addr = 64'h0;

  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      h_rvalid    = h_req_prev;
      cur_tag     = -2;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (inj) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0093;
        cur_tag     = -1;
        cur_addr    = 64'h0;
        inj         = 1'b0;
      end else if (memq.size() > 0 && memq[0].due == cyc) begin
        r           = memq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(r.addr);
        cur_tag     = r.tag;
        cur_addr    = r.addr;
      end
    end
  end

  // Model: a response is delivered only if it answers the newest request and
  // nothing (redirect/reset) has superseded that request since it was issued.
  bit          m_valid, m_live, m_idle, m_halt;
  logic [31:0] m_inst;
  logic [63:0] m_pc, m_next;
  int          m_live_tag;
  int          next_tag = 0;

  initial begin
    bit          nv;
    logic [31:0] ni;
    logic [63:0] np, nn;
    forever begin
      @(negedge clk);
      h_req_prev = h_req;
      if (rst) begin
        m_valid = 1'b0; m_inst = NOP; m_pc = 64'h0; m_next = 64'h0;
        m_live = 1'b0; m_idle = 1'b1; m_halt = 1'b0;
        memq.delete();
      end else begin
        chk("mdl_valid", {63'h0, inst_valid}, {63'h0, m_valid});
        if (m_valid) begin
          chk("mdl_inst", {32'h0, inst_out}, {32'h0, m_inst});
          chk("mdl_pc", inst_pc, m_pc);
        end
`ifdef FETCH_ALIGN_CHK_EN
        chk("mdl_fault", {63'h0, fetch_fault}, {63'h0, m_halt});
`endif
        if (imem_req) begin
          chk("mdl_req_addr", imem_addr, m_next);
          chk("mdl_req_legal", {60'h0, m_valid, m_live, m_halt, m_idle}, 64'h0);
          memq.push_back('{cyc + lat, imem_addr, next_tag});
          m_live     = 1'b1;
          m_live_tag = next_tag;
          next_tag++;
        end
        nv = m_valid; ni = m_inst; np = m_pc; nn = m_next;
        if (m_valid && !stall) nv = 1'b0;
        if (imem_rvalid && m_live && cur_tag == m_live_tag) begin
          nv = 1'b1; ni = imem_rdata; np = cur_addr; nn = cur_addr + 64'd4;
          m_live = 1'b0;
        end
        if (redirect_en && !m_idle && !m_halt) begin
          nv = 1'b0;
          m_live = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
          if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
          else nn = {redirect_pc[63:2], 2'b00};
`else
          nn = {redirect_pc[63:2], 2'b00};
`endif
        end
        m_valid = nv; m_inst = ni; m_pc = np; m_next = nn;
        m_idle = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input logic [63:0] exp_pc);
    int n = 0;
    do begin step(); n++; end while (!inst_valid && n < 30);
    chk({nm, "_seen"}, {63'h0, inst_valid}, 64'h1);
    chk({nm, "_pc"}, inst_pc, exp_pc);
    chk({nm, "_inst"}, {32'h0, inst_out}, {32'h0, mem_word(exp_pc)});
  endtask

  task automatic wait_req(input string nm, input logic [63:0] exp_addr);
    int n = 0;
    do begin step(); n++; end while (!imem_req && n < 30);
    chk({nm, "_seen"}, {63'h0, imem_req}, 64'h1);
    chk({nm, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic reset_state_chk(input string nm);
    chk({nm, "_req"}, {63'h0, imem_req}, 64'h0);
    chk({nm, "_addr"}, imem_addr, 64'h0);
    chk({nm, "_valid"}, {63'h0, inst_valid}, 64'h0);
    chk({nm, "_inst"}, {32'h0, inst_out}, {32'h0, NOP});
    chk({nm, "_pc"}, inst_pc, 64'h0);
`ifdef FETCH_ALIGN_CHK_EN
    chk({nm, "_fault"}, {63'h0, fetch_fault}, 64'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step(); step();
    rst = 1'b0;
    // cycle 0: IDLE
    reset_state_chk("rst0");
    chk("hi_rst_addr", h_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("c1_req", {63'h0, imem_req}, 64'h1);
    chk("c1_addr", imem_addr, 64'h0);
    chk("hi_c1_addr", h_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("c2_req", {63'h0, imem_req}, 64'h0);
    step();
    chk("c3_valid", {63'h0, inst_valid}, 64'h1);
    chk("c3_inst", {32'h0, inst_out}, 64'h0000_0000_00A0_0093);
    chk("c3_pc", inst_pc, 64'h0);
    chk("hi_c3_valid", {63'h0, h_valid}, 64'h1);
    chk("hi_c3_pc", h_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("hi_c3_inst", {32'h0, h_inst}, 64'h1234_5678);
    step();
    chk("c4_req", {63'h0, imem_req}, 64'h1);
    chk("c4_addr", imem_addr, 64'h4);
    chk("hi_c4_req", {63'h0, h_req}, 64'h1);
    chk("hi_c4_addr", h_addr, 64'h0);

    // word at 8 held for 5 stalled cycles
    wait_valid("w4", 64'h4);
    wait_valid("w8", 64'h8);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {63'h0, inst_valid}, 64'h1);
      chk("hold_pc", inst_pc, 64'h8);
      chk("hold_req", {63'h0, imem_req}, 64'h0);
    end
    stall = 1'b0;
    lat = 2;
    step();
    chk("after_hold_req", {63'h0, imem_req}, 64'h1);
    chk("after_hold_addr", imem_addr, 64'hC);

    // redirect while waiting; stale response lands one cycle later
    step();
    redirect_en = 1'b1; redirect_pc = 64'h100;
    step();
    redirect_en = 1'b0;
    chk("rd_wait_req", {63'h0, imem_req}, 64'h1);
    chk("rd_wait_addr", imem_addr, 64'h100);
    chk("rd_wait_valid", {63'h0, inst_valid}, 64'h0);
    wait_valid("w100", 64'h100);
    lat = 1;

    // redirect coincident with the response
    wait_req("r104", 64'h104);
    step();
    redirect_en = 1'b1; redirect_pc = 64'h40;
    step();
    redirect_en = 1'b0;
    chk("rd_same_valid", {63'h0, inst_valid}, 64'h0);
    chk("rd_same_req", {63'h0, imem_req}, 64'h1);
    chk("rd_same_addr", imem_addr, 64'h40);
    wait_valid("w40", 64'h40);
    wait_valid("w44", 64'h44);
    // redirect with a misaligned target while the word is held under stall
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h206;
    step();
    redirect_en = 1'b0;
    chk("rd_hold_valid", {63'h0, inst_valid}, 64'h0);
`ifdef FETCH_ALIGN_CHK_EN
    chk("fault_set", {63'h0, fetch_fault}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fault_noreq", {63'h0, imem_req}, 64'h0);
      chk("fault_sticky", {63'h0, fetch_fault}, 64'h1);
    end
    stall = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; inj = 1'b1;
    reset_state_chk("rst2");
`else
    chk("rd_hold_req", {63'h0, imem_req}, 64'h1);
    chk("rd_hold_addr", imem_addr, 64'h204);
    wait_valid("w204", 64'h204);
    step();
    step();
    chk("stall_keep_pc", inst_pc, 64'h204);
    stall = 1'b0;
    lat = 3;
    wait_req("r208", 64'h208);
    // reset mid-request beats redirect and stall; response injected in IDLE
    step();
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h300; stall = 1'b1;
    step();
    rst = 1'b0; redirect_en = 1'b0; stall = 1'b0; inj = 1'b1;
    reset_state_chk("rst2");
`endif
    step();
    chk("rst2_req", {63'h0, imem_req}, 64'h1);
    chk("rst2_addr", imem_addr, 64'h0);
    wait_valid("w0b", 64'h0);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
